// File: rtl/pc_fetch_ctrl_if.sv
// Signal bundle between the fetch sequencer and the pipeline (hazard unit, redirect sources, PC, imem).
// The master side is the sequencer; the slave side is the surrounding pipeline.
interface pc_fetch_ctrl_if;
    logic        hazard_stall;
    logic        imem_ready;
    logic        trap_req;
    logic [31:0] trap_vector;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic        halt_req;
    logic        resume;
    logic        pc_stall;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        imem_req;
    logic        flush_if;
    logic        flush_id;
    logic        redirect_pending;
    logic [1:0]  state;

    modport master (
        input  hazard_stall, imem_ready, trap_req, trap_vector,
               ex_branch_taken, ex_branch_target, id_jump, id_jump_target,
               halt_req, resume,
        output pc_stall, pc_src, pc_target, imem_req, flush_if, flush_id,
               redirect_pending, state
    );

    modport slave (
        output hazard_stall, imem_ready, trap_req, trap_vector,
               ex_branch_taken, ex_branch_target, id_jump, id_jump_target,
               halt_req, resume,
        input  pc_stall, pc_src, pc_target, imem_req, flush_if, flush_id,
               redirect_pending, state
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing controller: boot redirect, prioritised redirects (trap > branch > jump),
// holding of redirects that arrive while the PC is stalled, and halt/resume.
//
// state | meaning
// BOOT  | one cycle after reset, PC loads RESET_VECTOR
// RUN   | fetching; redirects applied directly or captured while stalled
// HALT  | fetch stopped; a trap or resume returns to RUN
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    pc_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Source encoding doubles as priority rank so captures compare numerically.
    localparam logic [1:0] SRC_NONE   = 2'd0;
    localparam logic [1:0] SRC_JUMP   = 2'd1;
    localparam logic [1:0] SRC_BRANCH = 2'd2;
    localparam logic [1:0] SRC_TRAP   = 2'd3;

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_src_q, pend_src_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic [1:0]  sel_src;
    logic [31:0] sel_tgt;
    logic        new_evt;
    logic        new_wins;
    logic        imem_req_c;
    logic        stall_c;

    always_comb begin
        sel_src = SRC_NONE;
        sel_tgt = '0;
        if (bus.trap_req) begin
            sel_src = SRC_TRAP;
            sel_tgt = bus.trap_vector;
        end else if (bus.ex_branch_taken) begin
            sel_src = SRC_BRANCH;
            sel_tgt = bus.ex_branch_target;
        end else if (bus.id_jump) begin
            sel_src = SRC_JUMP;
            sel_tgt = bus.id_jump_target;
        end
    end

    assign new_evt    = (sel_src != SRC_NONE);
    // pend_src_q is SRC_NONE when empty, so any new event wins then.
    assign new_wins   = new_evt && (sel_src >= pend_src_q);
    assign imem_req_c = (state_q == ST_RUN);
    assign stall_c    = bus.hazard_stall | (imem_req_c & ~bus.imem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pend_q     <= 1'b0;
            pend_src_q <= SRC_NONE;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_src_q <= pend_src_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_src_d = pend_src_q;
        pend_tgt_d = pend_tgt_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!stall_c) begin
                    pend_d     = 1'b0;
                    pend_src_d = SRC_NONE;
                    pend_tgt_d = '0;
                end else if (new_wins) begin
                    pend_d     = 1'b1;
                    pend_src_d = sel_src;
                    pend_tgt_d = sel_tgt;
                end
                if (bus.halt_req && !pend_q && !new_evt) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (bus.trap_req || bus.resume) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        bus.pc_stall  = 1'b0;
        bus.pc_src    = 1'b0;
        bus.pc_target = '0;
        bus.imem_req  = imem_req_c;
        bus.flush_if  = 1'b0;
        bus.flush_id  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                bus.pc_src    = 1'b1;
                bus.pc_target = RESET_VECTOR;
                bus.flush_if  = 1'b1;
                bus.flush_id  = 1'b1;
            end
            ST_RUN: begin
                bus.pc_stall = stall_c;
                bus.flush_if = new_evt | pend_q;
                bus.flush_id = (sel_src >= SRC_BRANCH);
                if (!stall_c) begin
                    if (new_wins) begin
                        bus.pc_src    = 1'b1;
                        bus.pc_target = sel_tgt;
                    end else if (pend_q) begin
                        bus.pc_src    = 1'b1;
                        bus.pc_target = pend_tgt_q;
                    end
                end
            end
            ST_HALT: begin
                bus.pc_stall = 1'b1;
                if (bus.trap_req) begin
                    bus.pc_stall  = 1'b0;
                    bus.pc_src    = 1'b1;
                    bus.pc_target = bus.trap_vector;
                    bus.flush_if  = 1'b1;
                    bus.flush_id  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.redirect_pending = pend_q;
    assign bus.state            = state_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table with a PC register model, then random
// stimulus checked against a rank-based behavioural model of the redirect rules.
module tb_pc_fetch_ctrl;
    localparam logic [31:0] RV = 32'h100;

    typedef struct packed {
        logic        hz;
        logic        rdy;
        logic        tr;
        logic [31:0] tv;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        hl;
        logic        rs;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        src;
        logic [31:0] tgt;
        logic        req;
        logic        fif;
        logic        fid;
        logic        pend;
        logic [1:0]  st;
    } out_t;

    typedef struct {
        string       nm;
        in_t         i;
        out_t        o;
        logic [31:0] pc;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if bus();
    pc_fetch_ctrl #(.RESET_VECTOR(RV)) dut (.clk(clk), .reset(reset), .bus(bus));

    // PC register as the pipeline sees it: stall beats pc_src.
    logic [31:0] pc_env;
    always @(posedge clk or posedge reset) begin
        if (reset) pc_env <= '0;
        else if (!bus.pc_stall) pc_env <= bus.pc_src ? bus.pc_target : pc_env + 32'd4;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: mode 0 boot, 1 run, 2 halt; pending redirect as (valid, rank, target).
    int          m_mode, n_mode;
    bit          m_pv, n_pv;
    int          m_prank, n_prank;
    logic [31:0] m_ptgt, n_ptgt;

    vec_t tbl[$];
    out_t boot_o;

    function automatic in_t ii(bit hz, bit rdy, bit tr, logic [31:0] tv, bit br, logic [31:0] bt,
                               bit jp, logic [31:0] jt, bit hl, bit rs);
        in_t r;
        r.hz = hz; r.rdy = rdy; r.tr = tr; r.tv = tv; r.br = br; r.bt = bt;
        r.jp = jp; r.jt = jt; r.hl = hl; r.rs = rs;
        return r;
    endfunction

    function automatic out_t oo(bit stall, bit src, logic [31:0] tgt, bit req, bit fif, bit fid,
                                bit pend, logic [1:0] st);
        out_t r;
        r.stall = stall; r.src = src; r.tgt = tgt; r.req = req;
        r.fif = fif; r.fid = fid; r.pend = pend; r.st = st;
        return r;
    endfunction

    function automatic out_t read_dut();
        return oo(bus.pc_stall, bus.pc_src, bus.pc_target, bus.imem_req, bus.flush_if,
                  bus.flush_id, bus.redirect_pending, bus.state);
    endfunction

    task automatic drive(input in_t i);
        bus.hazard_stall     = i.hz;
        bus.imem_ready       = i.rdy;
        bus.trap_req         = i.tr;
        bus.trap_vector      = i.tv;
        bus.ex_branch_taken  = i.br;
        bus.ex_branch_target = i.bt;
        bus.id_jump          = i.jp;
        bus.id_jump_target   = i.jt;
        bus.halt_req         = i.hl;
        bus.resume           = i.rs;
    endtask

    task automatic check_out(input string nm, input out_t a, input out_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got stall=%b src=%b tgt=%h req=%b fif=%b fid=%b pend=%b st=%0d, expected stall=%b src=%b tgt=%h req=%b fif=%b fid=%b pend=%b st=%0d",
                     nm, a.stall, a.src, a.tgt, a.req, a.fif, a.fid, a.pend, a.st,
                     e.stall, e.src, e.tgt, e.req, e.fif, e.fid, e.pend, e.st);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic model_eval(input in_t i, output out_t o);
        int          rank[3];
        bit          rq[3];
        logic [31:0] tg[3];
        int          best;
        logic [31:0] btgt;
        bit          stalled;
        rank = '{3, 2, 1};
        rq   = '{i.tr, i.br, i.jp};
        tg   = '{i.tv, i.bt, i.jt};
        best = 0;
        btgt = '0;
        for (int k = 0; k < 3; k++)
            if (rq[k] && rank[k] > best) begin
                best = rank[k];
                btgt = tg[k];
            end
        n_mode = m_mode; n_pv = m_pv; n_prank = m_prank; n_ptgt = m_ptgt;
        o = oo(0, 0, 32'h0, 0, 0, 0, m_pv, 2'(m_mode));
        if (m_mode == 0) begin
            o.src = 1; o.tgt = RV; o.fif = 1; o.fid = 1;
            n_mode = 1;
        end else if (m_mode == 1) begin
            stalled = i.hz || !i.rdy;
            o.req   = 1;
            o.stall = stalled;
            o.fif   = (best > 0) || m_pv;
            o.fid   = (best >= 2);
            if (!stalled) begin
                if (m_pv && best < m_prank) begin
                    o.src = 1; o.tgt = m_ptgt;
                end else if (best > 0) begin
                    o.src = 1; o.tgt = btgt;
                end
                n_pv = 0; n_prank = 0; n_ptgt = '0;
            end else if (best > 0 && (!m_pv || best >= m_prank)) begin
                n_pv = 1; n_prank = best; n_ptgt = btgt;
            end
            if (i.hl && !m_pv && best == 0) n_mode = 2;
        end else begin
            o.stall = 1;
            if (i.tr) begin
                o.stall = 0; o.src = 1; o.tgt = i.tv; o.fif = 1; o.fid = 1;
                n_mode = 1;
            end else if (i.rs) begin
                n_mode = 1;
            end
        end
    endtask

    task automatic model_commit();
        m_mode = n_mode; m_pv = n_pv; m_prank = n_prank; m_ptgt = n_ptgt;
    endtask

    task automatic model_reset();
        m_mode = 0; m_pv = 0; m_prank = 0; m_ptgt = '0;
    endtask

    // One clock cycle: drive at posedge+1, sample at negedge, commit model at posedge.
    task automatic step(input in_t i, input bit has_exp, input out_t e, input logic [31:0] epc,
                        input string nm);
        out_t mo;
        out_t rd;
        drive(i);
        model_eval(i, mo);
        @(negedge clk);
        rd = read_dut();
        check_out({nm, "/model"}, rd, mo);
        if (has_exp) begin
            check_out(nm, rd, e);
            check32({nm, "/pc"}, pc_env, epc);
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        #1;
        model_reset();
        check_out({nm, "/boot_out"}, read_dut(), boot_o);
        check32({nm, "/pc"}, pc_env, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic add(input string nm, input in_t i, input out_t o, input logic [31:0] pc);
        vec_t v;
        v.nm = nm; v.i = i; v.o = o; v.pc = pc;
        tbl.push_back(v);
    endtask

    initial begin
        in_t  idle, hz1, ri;
        out_t run_idle, halted, dummy;
        idle     = ii(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        hz1      = ii(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        boot_o   = oo(0, 1, RV, 0, 1, 1, 0, 0);
        run_idle = oo(0, 0, 0, 1, 0, 0, 0, 1);
        halted   = oo(1, 0, 0, 0, 0, 0, 0, 2);
        dummy    = oo(0, 0, 0, 0, 0, 0, 0, 0);

        add("boot",           idle, boot_o, 32'h0);
        add("run0",           idle, run_idle, 32'h100);
        add("run1",           idle, run_idle, 32'h104);
        add("br_direct",      ii(0, 1, 0, 0, 1, 32'h200, 0, 0, 0, 0), oo(0, 1, 32'h200, 1, 1, 1, 0, 1), 32'h108);
        add("br_capture",     ii(1, 1, 0, 0, 1, 32'h300, 0, 0, 0, 0), oo(1, 0, 0, 1, 1, 1, 0, 1), 32'h200);
        add("pend_hold1",     hz1, oo(1, 0, 0, 1, 1, 0, 1, 1), 32'h200);
        add("pend_hold2",     hz1, oo(1, 0, 0, 1, 1, 0, 1, 1), 32'h200);
        add("pend_apply",     idle, oo(0, 1, 32'h300, 1, 1, 0, 1, 1), 32'h200);
        add("prio_direct",    ii(0, 1, 1, 32'h80, 0, 0, 1, 32'h400, 0, 0), oo(0, 1, 32'h80, 1, 1, 1, 0, 1), 32'h300);
        add("jump_capture",   ii(1, 1, 0, 0, 0, 0, 1, 32'h400, 0, 0), oo(1, 0, 0, 1, 1, 0, 0, 1), 32'h80);
        add("trap_overwrite", ii(1, 1, 1, 32'h80, 0, 0, 0, 0, 0, 0), oo(1, 0, 0, 1, 1, 1, 1, 1), 32'h80);
        add("jump_dropped",   ii(1, 1, 0, 0, 0, 0, 1, 32'h440, 0, 0), oo(1, 0, 0, 1, 1, 0, 1, 1), 32'h80);
        add("trap_apply",     idle, oo(0, 1, 32'h80, 1, 1, 0, 1, 1), 32'h80);
        add("imem_capture",   ii(0, 0, 0, 0, 0, 0, 1, 32'h500, 0, 0), oo(1, 0, 0, 1, 1, 0, 0, 1), 32'h80);
        add("imem_hold",      ii(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), oo(1, 0, 0, 1, 1, 0, 1, 1), 32'h80);
        add("imem_apply",     idle, oo(0, 1, 32'h500, 1, 1, 0, 1, 1), 32'h80);
        add("halt_req",       ii(0, 1, 0, 0, 0, 0, 0, 0, 1, 0), run_idle, 32'h500);
        add("halted",         idle, halted, 32'h504);
        add("halt_frozen",    idle, halted, 32'h504);
        add("halt_trap",      ii(0, 1, 1, 32'h80, 1, 32'h999, 0, 0, 0, 1), oo(0, 1, 32'h80, 0, 1, 1, 0, 2), 32'h504);
        add("post_trap",      idle, run_idle, 32'h80);
        add("halt_blocked",   ii(0, 1, 0, 0, 0, 0, 1, 32'h600, 1, 0), oo(0, 1, 32'h600, 1, 1, 0, 0, 1), 32'h84);
        add("halt_stalled",   ii(1, 1, 0, 0, 0, 0, 0, 0, 1, 0), oo(1, 0, 0, 1, 0, 0, 0, 1), 32'h600);
        add("resume",         ii(0, 1, 0, 0, 0, 0, 0, 0, 0, 1), halted, 32'h600);
        add("post_resume",    idle, run_idle, 32'h600);
        add("br_capture2",    ii(1, 1, 0, 0, 1, 32'h700, 0, 0, 0, 0), oo(1, 0, 0, 1, 1, 1, 0, 1), 32'h604);
        add("new_beats_pend", ii(0, 1, 1, 32'h900, 0, 0, 0, 0, 0, 0), oo(0, 1, 32'h900, 1, 1, 1, 1, 1), 32'h604);
        add("br_capture3",    ii(1, 1, 0, 0, 1, 32'hA00, 0, 0, 0, 0), oo(1, 0, 0, 1, 1, 1, 0, 1), 32'h900);

        drive(idle);
        model_reset();
        #1;
        do_reset("por");

        foreach (tbl[k]) step(tbl[k].i, 1'b1, tbl[k].o, tbl[k].pc, tbl[k].nm);

        // Reset while a branch is pending: pending must be discarded and BOOT reissued.
        check32("pend_before_rst", {31'b0, bus.redirect_pending}, 32'h1);
        do_reset("rst_pending");
        step(idle, 1'b1, boot_o, 32'h0, "boot_after_rst");
        step(idle, 1'b1, run_idle, RV, "run_after_rst");

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rand_rst");
            end else begin
                ri.hz  = ($urandom_range(0, 9) < 3);
                ri.rdy = ($urandom_range(0, 3) != 0);
                ri.tr  = ($urandom_range(0, 19) == 0);
                ri.tv  = $urandom;
                ri.br  = ($urandom_range(0, 7) == 0);
                ri.bt  = $urandom;
                ri.jp  = ($urandom_range(0, 7) == 0);
                ri.jt  = $urandom;
                ri.hl  = ($urandom_range(0, 11) == 0);
                ri.rs  = ($urandom_range(0, 4) == 0);
                step(ri, 1'b0, dummy, 32'h0, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
